// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its debug dump sequencer.
//   REG_IDX_W / REG_COUNT : register index width and register count
//   dump_state_t          : dump sequencer state encoding
//   next_idx()            : mod-32 index increment that can step over x0
package regfile_pkg;

  localparam int REG_IDX_W = 5;
  localparam int REG_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } dump_state_t;

  // Wraps 31 -> 0. When skip_x0 is set, the hard-wired zero register is
  // stepped over, so the increment lands on index 1 instead.
  function automatic logic [REG_IDX_W-1:0] next_idx(input logic [REG_IDX_W-1:0] idx,
                                                    input logic                 skip_x0);
    logic [REG_IDX_W-1:0] n;
    n = idx + 1'b1;
    if (skip_x0 && (n == '0)) n = REG_IDX_W'(1);
    return n;
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Debug dump sequencer for the 32-entry register file. On start it walks the
// index range first_idx..last_idx (wrapping 31->0) on the register file debug
// read port and streams each value, tagged with its index, over valid/ready.
// While a dump runs, hold tells the core to suppress register file writes.
//   clk, reset          : clock, asynchronous active-high reset
//   start, abort        : dump request (IDLE only), cancel (READ/SEND only)
//   first_idx, last_idx : inclusive index range, latched on accepted start
//   dbg_sel, dbg_data   : register file debug select / combinational data
//   out_valid/ready     : entry handshake; out_data, out_idx, out_last payload
//   busy, hold, done    : dump active, core write hold, completion pulse
module regfile_dump_ctrl
  import regfile_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit SKIP_X0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [REG_IDX_W-1:0] first_idx,
  input  logic [REG_IDX_W-1:0] last_idx,
  output logic [REG_IDX_W-1:0] dbg_sel,
  input  logic [WIDTH-1:0]     dbg_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [REG_IDX_W-1:0] out_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic                 hold,
  output logic                 done
);

  dump_state_t          state, state_nxt;
  logic [REG_IDX_W-1:0] cur_idx;
  logic [REG_IDX_W-1:0] end_idx;
  logic [REG_IDX_W-1:0] start_idx;
  logic [REG_IDX_W-1:0] stop_idx;
  logic [REG_IDX_W-1:0] step_idx;
  logic                 empty_dump;
  logic                 xfer;

  assign xfer       = out_valid & out_ready;
  assign empty_dump = SKIP_X0 && (first_idx == '0) && (last_idx == '0);
  assign start_idx  = (SKIP_X0 && (first_idx == '0)) ? REG_IDX_W'(1) : first_idx;
  // x0 is never visited when skipped, so a range ending at 0 really ends at
  // 31; otherwise the end match would never fire after the wrap.
  assign stop_idx   = (SKIP_X0 && (last_idx == '0)) ? '1 : last_idx;
  assign step_idx   = next_idx(cur_idx, SKIP_X0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = empty_dump ? DONE : READ;
      READ: state_nxt = abort ? IDLE : SEND;
      SEND: begin
        if (abort)     state_nxt = IDLE;
        else if (xfer) state_nxt = out_last ? DONE : READ;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      hold  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      // Status flags decode the next state so they line up with the state
      // register while still coming straight from flops.
      busy  <= (state_nxt != IDLE);
      hold  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_idx   <= '0;
      end_idx   <= '0;
      dbg_sel   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cur_idx <= start_idx;
            end_idx <= stop_idx;
            // dbg_sel only moves when a READ follows, so it already shows
            // cur_idx throughout READ and keeps its value elsewhere.
            if (!empty_dump) dbg_sel <= start_idx;
          end
        end
        READ: begin
          if (!abort) begin
            out_data  <= dbg_data;
            out_idx   <= cur_idx;
            out_last  <= (cur_idx == end_idx);
            out_valid <= 1'b1;
          end
        end
        SEND: begin
          if (abort || xfer) out_valid <= 1'b0;
          if (!abort && xfer && !out_last) begin
            cur_idx <= step_idx;
            dbg_sel <= step_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/regfile_dump_ctrl.md
Name: regfile_dump_ctrl

Overview:
- Debug dump sequencer for the 32-entry register file.
- On command, it walks a contiguous index range on the register file's debug read port (Debug_Source_select / Debug_out) and streams each register value, tagged with its index, to a debug consumer over a valid/ready handshake.
- It asserts a write-hold to the core while a dump is in progress, so the dumped snapshot is consistent.
- It sits between the core top level, the register file debug port and the debug/UART link.

Parameters:
- WIDTH, 32, register data width; must match the register file WIDTH.
- SKIP_X0, 1, when 1 index 0 is never emitted (hard-wired zero register).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle dump request; sampled only in IDLE.
- abort  in  1  cancel the dump in progress.
- first_idx  in  5  first register index; latched on an accepted start.
- last_idx  in  5  last register index; latched on an accepted start.
- dbg_sel  out  5  drives the register file Debug_Source_select.
- dbg_data  in  WIDTH  from the register file Debug_out (combinational read).
- out_valid  out  1  dump entry available.
- out_ready  in  1  consumer accepts the entry.
- out_data  out  WIDTH  captured register value.
- out_idx  out  5  index of out_data.
- out_last  out  1  qualifies the final entry of a dump.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- hold  out  1  core must suppress register file write_enable while high.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. All outputs are 0: dbg_sel, out_valid, out_data, out_idx, out_last, busy, hold, done. Internal cur_idx and end_idx are 0.
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - start=1 latches cur_idx=first_idx and end_idx=last_idx, then goes to READ.
  - If SKIP_X0=1 and first_idx=0, cur_idx=1 instead.
  - If SKIP_X0=1 and first_idx=last_idx=0, go straight to DONE; nothing is emitted.
- READ (1 cycle):
  - dbg_sel=cur_idx.
  - At the clock edge, out_data<=dbg_data, out_idx<=cur_idx, out_last<=(cur_idx==end_idx), out_valid<=1; go to SEND.
- SEND: out_valid=1 and out_data/out_idx/out_last are held stable until out_valid&out_ready.
  - On transfer with out_last=1: out_valid<=0, go to DONE.
  - Otherwise: out_valid<=0, cur_idx<=cur_idx+1 (mod 32), go to READ.
  - If SKIP_X0=1 and the incremented index is 0, use 1 instead. The end-match check still applies to the skipped-to index.
- DONE (1 cycle): done=1, then IDLE.
- Range wrap: first_idx>last_idx wraps 31->0.
  - Entry count = ((last_idx-first_idx) mod 32)+1, minus 1 if the range contains index 0 and SKIP_X0=1.
  - first_idx==last_idx emits exactly 1 entry (subject to the SKIP_X0 rule).
- Throughput: 1 entry per 2 cycles with out_ready held high. Latency from start to the first out_valid is 2 cycles.
- busy and hold are high in READ, SEND and DONE. hold is registered, so it rises the cycle after start.
- abort in READ or SEND: go to IDLE next cycle with out_valid<=0, no done pulse, and busy/hold drop.
  - If out_valid&out_ready occur in the same cycle as abort, the transfer is complete for the consumer.
  - abort in IDLE or DONE is ignored; DONE still pulses.
- start while not IDLE is ignored; first_idx/last_idx are sampled only on an accepted start.
- Simultaneous start and abort in IDLE: start is accepted.
- dbg_sel holds its last value outside READ (not forced to 0) and returns to 0 only on reset.

Decomposition:
- Shared package (regfile_pkg):
  - REG_IDX_W=5, REG_COUNT=32.
  - dump_state_t enum {IDLE, READ, SEND, DONE}.
  - A next_idx function (mod-32 increment with optional x0 skip).
- Single module; no sub-module is needed. The index counter is a few lines of logic.

Test Plan:
- first=3, last=5, out_ready=1, regs r3..r5=0xA,0xB,0xC -> 3 transfers (idx 3,4,5 / data A,B,C), out_last on idx 5, done pulse 1 cycle later, first out_valid 2 cycles after start.
- first=30, last=2, SKIP_X0=1 -> idx sequence 30,31,1,2 (4 entries); out_last only on 2.
- out_ready held low 10 cycles in SEND -> out_valid, out_data and out_idx stable throughout; hold=1; the entry transfers on the first ready cycle.
- abort asserted in the second SEND of a 0..31 dump -> IDLE next cycle, busy/hold=0, no done; a new start with first=4, last=4 then emits exactly idx 4.
- reset asserted mid-SEND (asynchronously, between edges) -> all outputs 0 immediately; state is IDLE after release.
- start pulsed again while busy with different first/last -> ignored; the original sequence completes unchanged.
